multdiv_sequencer: RTL and testbench

- Sequences the shared iterative multiply/divide unit for the pipelined processor.
- Accepts one mult/div issue from the execute stage and pulses the unit's start control.
- Waits for the result-ready flag, then requests the register-file write port.
- Routes unit exceptions to the status register and generates the pipeline stall.

---
 rtl/multdiv_pkg.sv | 21 ++
 rtl/multdiv_timeout_counter.sv | 36 +++
 rtl/multdiv_sequencer.sv | 169 ++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer and its helpers.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    localparam int TIMEOUT_CYCLES = 40;
    localparam int STATUS_REG_IDX = 30;
    localparam int MULT_EXC       = 4;
    localparam int DIV_EXC        = 5;

endpackage

// File: rtl/multdiv_timeout_counter.sv
// Counts WAIT cycles of the multiply/divide sequencer; expired marks the last allowed cycle.
module multdiv_timeout_counter #(
    parameter int TIMEOUT = 40
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter holds the number of WAIT cycles already completed.
    assign expired_o = (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Issue/start/wait/writeback sequencer for the shared iterative multiply/divide unit.
// Optional operand-hazard stalling (instead of a full freeze) when MULTDIV_SCOREBOARD_EN is defined.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int REG_W         = 5,
    parameter int TIMEOUT       = TIMEOUT_CYCLES,
    parameter int STATUS_REG    = STATUS_REG_IDX,
    parameter int MULT_EXC_CODE = MULT_EXC,
    parameter int DIV_EXC_CODE  = DIV_EXC
) (
    input  logic              clock,
    input  logic              reset,
`ifdef MULTDIV_SCOREBOARD_EN
    input  logic              src_valid,
    input  logic [REG_W-1:0]  src_rs,
    input  logic [REG_W-1:0]  src_rt,
`endif
    input  logic              issue_valid,
    input  logic              issue_op,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic [REG_W-1:0]  issue_rd,
    output logic              issue_ready,
    output logic              md_ctrl_mult,
    output logic              md_ctrl_div,
    output logic [DATA_W-1:0] md_operand_a,
    output logic [DATA_W-1:0] md_operand_b,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_result_rdy,
    output logic              wb_req,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_ack,
    output logic              stall,
    output logic              busy,
    output logic              timeout_err
);

    function automatic logic [DATA_W-1:0] exc_status(input op_e op);
        return (op == OP_DIV) ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);
    endfunction

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              exc_q, exc_d;
    logic              tmo_q, tmo_d;

    logic              cnt_clear;
    logic              cnt_en;
    logic              cnt_expired;

    multdiv_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clock),
        .rst_ni    (reset),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_en),
        .expired_o (cnt_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rd_d         = rd_q;
        res_d        = res_q;
        exc_d        = exc_q;
        tmo_d        = tmo_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        issue_ready  = 1'b0;
        md_ctrl_mult = 1'b0;
        md_ctrl_div  = 1'b0;
        wb_req       = 1'b0;
        wb_reg       = '0;
        wb_data      = '0;
        case (state_q)
            ST_IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    op_d    = op_e'(issue_op);
                    a_d     = issue_a;
                    b_d     = issue_b;
                    rd_d    = issue_rd;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                md_ctrl_mult = (op_q == OP_MULT);
                md_ctrl_div  = (op_q == OP_DIV);
                cnt_clear    = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                // A result arriving in the last allowed cycle beats the timeout.
                if (md_result_rdy) begin
                    res_d   = md_result;
                    exc_d   = md_exception;
                    state_d = ST_WB;
                end else if (cnt_expired) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                wb_req = 1'b1;
                if (exc_q) begin
                    wb_reg  = REG_W'(STATUS_REG);
                    wb_data = exc_status(op_q);
                end else begin
                    wb_reg  = rd_q;
                    wb_data = res_q;
                end
                if (wb_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy         = (state_q != ST_IDLE);
    assign timeout_err  = tmo_q;
    assign md_operand_a = busy ? a_q : '0;
    assign md_operand_b = busy ? b_q : '0;

`ifdef MULTDIV_SCOREBOARD_EN
    logic hazard;
    assign hazard = busy && src_valid && ((src_rs == rd_q) || (src_rt == rd_q)) && (rd_q != '0);
    assign stall  = hazard || (issue_valid && issue_ready) || (issue_valid && busy);
`else
    assign stall  = busy || (issue_valid && issue_ready);
`endif

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: scripted scenarios and randomized operations checked
// against a behavioural model of the unit and of the expected writeback.
module tb_multdiv_sequencer;

    localparam int DATA_W     = 32;
    localparam int REG_W      = 5;
    localparam int TIMEOUT    = 40;
    localparam int STATUS_REG = 30;
    localparam int MULT_EXC   = 4;
    localparam int DIV_EXC    = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              issue_valid = 1'b0;
    logic              issue_op = 1'b0;
    logic [DATA_W-1:0] issue_a = '0;
    logic [DATA_W-1:0] issue_b = '0;
    logic [REG_W-1:0]  issue_rd = '0;
    logic              issue_ready;
    logic              md_ctrl_mult;
    logic              md_ctrl_div;
    logic [DATA_W-1:0] md_operand_a;
    logic [DATA_W-1:0] md_operand_b;
    logic [DATA_W-1:0] md_result = '0;
    logic              md_exception = 1'b0;
    logic              md_result_rdy = 1'b0;
    logic              wb_req;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ack = 1'b0;
    logic              stall;
    logic              busy;
    logic              timeout_err;
`ifdef MULTDIV_SCOREBOARD_EN
    logic              src_valid = 1'b0;
    logic [REG_W-1:0]  src_rs = '0;
    logic [REG_W-1:0]  src_rt = '0;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    logic model_tmo = 1'b0;

    multdiv_sequencer #(
        .DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT),
        .STATUS_REG(STATUS_REG), .MULT_EXC_CODE(MULT_EXC), .DIV_EXC_CODE(DIV_EXC)
    ) dut (
        .clock(clock), .reset(reset),
`ifdef MULTDIV_SCOREBOARD_EN
        .src_valid(src_valid), .src_rs(src_rs), .src_rt(src_rt),
`endif
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_a(issue_a),
        .issue_b(issue_b), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
        .md_result(md_result), .md_exception(md_exception), .md_result_rdy(md_result_rdy),
        .wb_req(wb_req), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ack(wb_ack),
        .stall(stall), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    typedef struct {
        logic              op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_W-1:0]  rd;
        int                lat;        // cycles from start pulse to result; <1 means never
        logic              exc;
        logic [DATA_W-1:0] res;
        int                ack_delay;
    } op_t;

    typedef struct {
        int                pm;
        int                pd;
        int                wb_lat;     // issue cycle to first wb_req, -1 if none
        logic [REG_W-1:0]  wbr;
        logic [DATA_W-1:0] wbd;
        bit                wb_stable;
        bit                stall_ok;
        bit                opnd_ok;
        logic              ready_at_issue;
        logic              stall_at_issue;
        int                end_cyc;    // first cycle after start with busy low
        logic              ready_end;
        int                to_cyc;
        logic              tmo_end;
    } obs_t;

    // Behavioural model of the unit and of the writeback the sequencer must request.
    function automatic logic [DATA_W-1:0] unit_result(input logic op, input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
        if (op) return (b == 0) ? '1 : a / b;
        return a * b;
    endfunction

    function automatic op_t mk(input logic op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic [REG_W-1:0] rd, input int lat, input logic exc, input int ack);
        op_t t;
        t.op = op; t.a = a; t.b = b; t.rd = rd; t.lat = lat; t.exc = exc;
        t.res = unit_result(op, a, b); t.ack_delay = ack;
        return t;
    endfunction

    function automatic logic [REG_W-1:0] exp_reg(input op_t t);
        return t.exc ? REG_W'(STATUS_REG) : t.rd;
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input op_t t);
        if (t.exc) return t.op ? DATA_W'(DIV_EXC) : DATA_W'(MULT_EXC);
        return t.res;
    endfunction

    function automatic int exp_wb_lat(input op_t t);
        return (t.lat >= 1 && t.lat <= TIMEOUT) ? t.lat + 2 : -1;
    endfunction

    function automatic int exp_end(input op_t t);
        return (exp_wb_lat(t) < 0) ? TIMEOUT + 1 : t.lat + 2 + t.ack_delay;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one op, plays the unit and the write port, and records what the DUT did.
    task automatic run_op(input op_t t, input bit hold, input op_t nxt, output obs_t o);
        int start_cyc = -1000;
        int wb_cycles = 0;
        bit exp_stall;
`ifdef MULTDIV_SCOREBOARD_EN
        exp_stall = hold;
`else
        exp_stall = 1'b1;
`endif
        o.pm = 0; o.pd = 0; o.wb_lat = -1; o.wbr = '0; o.wbd = '0;
        o.wb_stable = 1; o.stall_ok = 1; o.opnd_ok = 1;
        o.end_cyc = -1; o.ready_end = 0; o.to_cyc = -1; o.tmo_end = 0;
        issue_valid = 1; issue_op = t.op; issue_a = t.a; issue_b = t.b; issue_rd = t.rd;
        #1;
        o.ready_at_issue = issue_ready;
        o.stall_at_issue = stall;
        for (int cyc = 0; cyc < 200; cyc++) begin
            tick();
            if (hold) begin
                issue_valid = 1; issue_op = nxt.op; issue_a = nxt.a; issue_b = nxt.b; issue_rd = nxt.rd;
            end else begin
                issue_valid = 0;
            end
            md_result_rdy = (t.lat >= 1) && (cyc == start_cyc + t.lat);
            md_result     = md_result_rdy ? t.res : $urandom;
            md_exception  = md_result_rdy ? t.exc : 1'($urandom);
            wb_ack        = wb_req && (wb_cycles == t.ack_delay);
            #1;
            if (md_ctrl_mult) o.pm++;
            if (md_ctrl_div) o.pd++;
            if ((md_ctrl_mult || md_ctrl_div) && start_cyc < 0) start_cyc = cyc;
            if (busy) begin
                if (stall !== exp_stall) o.stall_ok = 0;
                if (md_operand_a !== t.a || md_operand_b !== t.b) o.opnd_ok = 0;
            end
            if (wb_req) begin
                if (wb_cycles == 0) begin
                    o.wb_lat = cyc + 1; o.wbr = wb_reg; o.wbd = wb_data;
                end else if (wb_reg !== o.wbr || wb_data !== o.wbd) begin
                    o.wb_stable = 0;
                end
                wb_cycles++;
            end
            if (timeout_err && o.to_cyc < 0) o.to_cyc = cyc;
            if (!busy) begin
                o.end_cyc = cyc; o.ready_end = issue_ready; o.tmo_end = timeout_err;
                break;
            end
        end
        md_result_rdy = 0;
        wb_ack = 0;
        if (!hold) issue_valid = 0;
    endtask

    task automatic test_reset();
        #2 reset = 0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (issue_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", issue_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if ({stall, wb_req, md_ctrl_mult, md_ctrl_div, timeout_err} !== 5'b0)
            $display("FAIL rst_ctrl: got %b want 00000", {stall, wb_req, md_ctrl_mult, md_ctrl_div, timeout_err}); else n_pass++;
        n_checks++; if ({md_operand_a, md_operand_b, wb_data, wb_reg} !== '0)
            $display("FAIL rst_data: got %h want 0", {md_operand_a, md_operand_b, wb_data, wb_reg}); else n_pass++;
        reset = 1;
        tick();
        n_checks++; if (issue_ready !== 1'b1 || busy !== 1'b0 || stall !== 1'b0)
            $display("FAIL idle_after_rst: got ready=%b busy=%b stall=%b want 1 0 0", issue_ready, busy, stall); else n_pass++;
    endtask

    task automatic test_mult();
        op_t t = mk(1'b0, 32'd7, 32'd6, 5'd3, 32, 1'b0, 0);
        obs_t o;
        run_op(t, 0, t, o);
        n_checks++; if (o.ready_at_issue !== 1'b1 || o.stall_at_issue !== 1'b1)
            $display("FAIL mult_issue: got ready=%b stall=%b want 1 1", o.ready_at_issue, o.stall_at_issue); else n_pass++;
        n_checks++; if (o.pm != 1 || o.pd != 0) $display("FAIL mult_pulse: got mult=%0d div=%0d want 1 0", o.pm, o.pd); else n_pass++;
        n_checks++; if (o.wb_lat != 34) $display("FAIL mult_latency: got %0d want 34", o.wb_lat); else n_pass++;
        n_checks++; if (o.wbr !== 5'd3 || o.wbd !== 32'd42)
            $display("FAIL mult_wb: got reg=%0d data=%0d want 3 42", o.wbr, o.wbd); else n_pass++;
        n_checks++; if (!o.stall_ok || !o.opnd_ok) $display("FAIL mult_busy: got stall_ok=%b opnd_ok=%b want 1 1", o.stall_ok, o.opnd_ok); else n_pass++;
        n_checks++; if (o.end_cyc != 34 || o.ready_end !== 1'b1)
            $display("FAIL mult_idle: got end=%0d ready=%b want 34 1", o.end_cyc, o.ready_end); else n_pass++;
    endtask

    task automatic test_exceptions();
        op_t t;
        obs_t o;
        t = mk(1'b1, 32'd5, 32'd0, 5'd7, 10, 1'b1, 0);
        run_op(t, 0, t, o);
        n_checks++; if (o.pd != 1 || o.pm != 0) $display("FAIL div_pulse: got mult=%0d div=%0d want 0 1", o.pm, o.pd); else n_pass++;
        n_checks++; if (o.wbr !== 5'd30 || o.wbd !== 32'd5)
            $display("FAIL div_exc_wb: got reg=%0d data=%0d want 30 5", o.wbr, o.wbd); else n_pass++;
        t = mk(1'b0, 32'h8000_0000, 32'd4, 5'd9, 5, 1'b1, 1);
        run_op(t, 0, t, o);
        n_checks++; if (o.wbr !== 5'd30 || o.wbd !== 32'd4)
            $display("FAIL mult_exc_wb: got reg=%0d data=%0d want 30 4", o.wbr, o.wbd); else n_pass++;
        n_checks++; if (o.end_cyc != exp_end(t)) $display("FAIL mult_exc_end: got %0d want %0d", o.end_cyc, exp_end(t)); else n_pass++;
    endtask

    task automatic test_timeout();
        op_t t;
        obs_t o;
        t = mk(1'b1, 32'd100, 32'd3, 5'd4, 0, 1'b0, 0);
        run_op(t, 0, t, o);
        n_checks++; if (o.wb_lat != -1) $display("FAIL tmo_no_wb: got wb at %0d want none", o.wb_lat); else n_pass++;
        n_checks++; if (o.to_cyc != TIMEOUT + 1 || o.end_cyc != TIMEOUT + 1)
            $display("FAIL tmo_cycle: got err=%0d idle=%0d want %0d %0d", o.to_cyc, o.end_cyc, TIMEOUT + 1, TIMEOUT + 1); else n_pass++;
        n_checks++; if (o.tmo_end !== 1'b1 || o.ready_end !== 1'b1)
            $display("FAIL tmo_state: got err=%b ready=%b want 1 1", o.tmo_end, o.ready_end); else n_pass++;
        // Result in the very last WAIT cycle must still be written back.
        t = mk(1'b0, 32'd123, 32'd456, 5'd11, TIMEOUT, 1'b0, 0);
        run_op(t, 0, t, o);
        n_checks++; if (o.ready_at_issue !== 1'b1) $display("FAIL tmo_next_issue: got %b want 1", o.ready_at_issue); else n_pass++;
        n_checks++; if (o.wb_lat != TIMEOUT + 2 || o.wbd !== exp_data(t) || o.wbr !== exp_reg(t))
            $display("FAIL tmo_edge_rdy: got lat=%0d data=%h reg=%0d want %0d %h %0d",
                     o.wb_lat, o.wbd, o.wbr, TIMEOUT + 2, exp_data(t), exp_reg(t)); else n_pass++;
        t = mk(1'b0, 32'd2, 32'd3, 5'd12, TIMEOUT + 1, 1'b0, 0);
        run_op(t, 0, t, o);
        n_checks++; if (o.wb_lat != -1 || o.end_cyc != TIMEOUT + 1)
            $display("FAIL tmo_late_rdy: got wb=%0d idle=%0d want -1 %0d", o.wb_lat, o.end_cyc, TIMEOUT + 1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        op_t t1 = mk(1'b0, 32'hDEAD_BEEF, 32'd3, 5'd13, 4, 1'b0, 3);
        op_t t2 = mk(1'b1, 32'd1000, 32'd7, 5'd14, 6, 1'b0, 0);
        obs_t o;
        run_op(t1, 1, t2, o);
        n_checks++; if (!o.wb_stable) $display("FAIL b2b_wb_hold: got unstable want stable"); else n_pass++;
        n_checks++; if (o.wbr !== exp_reg(t1) || o.wbd !== exp_data(t1))
            $display("FAIL b2b_wb1: got reg=%0d data=%h want %0d %h", o.wbr, o.wbd, exp_reg(t1), exp_data(t1)); else n_pass++;
        n_checks++; if (o.end_cyc != exp_end(t1) || o.pm + o.pd != 1)
            $display("FAIL b2b_ignore_busy: got end=%0d pulses=%0d want %0d 1", o.end_cyc, o.pm + o.pd, exp_end(t1)); else n_pass++;
        n_checks++; if (!o.opnd_ok) $display("FAIL b2b_operands: got changed want held"); else n_pass++;
        run_op(t2, 0, t2, o);
        n_checks++; if (o.ready_at_issue !== 1'b1 || o.wb_lat != exp_wb_lat(t2))
            $display("FAIL b2b_second: got ready=%b lat=%0d want 1 %0d", o.ready_at_issue, o.wb_lat, exp_wb_lat(t2)); else n_pass++;
        n_checks++; if (o.wbr !== exp_reg(t2) || o.wbd !== exp_data(t2))
            $display("FAIL b2b_wb2: got reg=%0d data=%h want %0d %h", o.wbr, o.wbd, exp_reg(t2), exp_data(t2)); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int spurious = 0;
        issue_valid = 1; issue_op = 1'b0; issue_a = 32'd9; issue_b = 32'd9; issue_rd = 5'd15;
        tick();
        issue_valid = 0;
        repeat (5) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %b want 1", busy); else n_pass++;
        reset = 0;
        #1;
        n_checks++; if ({busy, wb_req, md_ctrl_mult, md_ctrl_div, timeout_err, stall} !== 6'b0 || issue_ready !== 1'b1)
            $display("FAIL midrst_outputs: got busy/wb/mul/div/tmo/stall=%b ready=%b want 000000 1",
                     {busy, wb_req, md_ctrl_mult, md_ctrl_div, timeout_err, stall}, issue_ready); else n_pass++;
        n_checks++; if (md_operand_a !== '0) $display("FAIL midrst_operand: got %h want 0", md_operand_a); else n_pass++;
        tick();
        reset = 1;
        md_result_rdy = 1; md_result = 32'd81; md_exception = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wb_req || busy || md_ctrl_mult || md_ctrl_div) spurious++;
        end
        md_result_rdy = 0;
        n_checks++; if (spurious != 0) $display("FAIL midrst_late_rdy: got %0d active cycles want 0", spurious); else n_pass++;
        model_tmo = 1'b0;
    endtask

    task automatic test_random();
        op_t t;
        obs_t o;
        for (int i = 0; i < 10; i++) begin
            t = mk(1'($urandom), $urandom, $urandom_range(0, 20), 5'($urandom),
                   $urandom_range(1, TIMEOUT + 4), 1'b0, $urandom_range(0, 3));
            t.exc = ($urandom_range(0, 3) == 0) || (t.op && t.b == 0);
            run_op(t, 0, t, o);
            if (t.lat > TIMEOUT) model_tmo = 1'b1;
            n_checks++; if (o.wb_lat != exp_wb_lat(t) || o.end_cyc != exp_end(t))
                $display("FAIL rnd%0d_timing: got lat=%0d end=%0d want %0d %0d", i, o.wb_lat, o.end_cyc, exp_wb_lat(t), exp_end(t)); else n_pass++;
            n_checks++; if ((t.op ? o.pd : o.pm) != 1 || (t.op ? o.pm : o.pd) != 0)
                $display("FAIL rnd%0d_pulse: got mult=%0d div=%0d op=%b", i, o.pm, o.pd, t.op); else n_pass++;
            n_checks++; if (o.tmo_end !== model_tmo) $display("FAIL rnd%0d_tmo: got %b want %b", i, o.tmo_end, model_tmo); else n_pass++;
            if (exp_wb_lat(t) >= 0) begin
                n_checks++; if (o.wbr !== exp_reg(t) || o.wbd !== exp_data(t))
                    $display("FAIL rnd%0d_wb: got reg=%0d data=%h want %0d %h", i, o.wbr, o.wbd, exp_reg(t), exp_data(t)); else n_pass++;
            end
        end
    endtask

`ifdef MULTDIV_SCOREBOARD_EN
    task automatic test_scoreboard();
        issue_valid = 1; issue_op = 1'b0; issue_a = 32'd3; issue_b = 32'd3; issue_rd = 5'd8;
        tick();
        issue_valid = 0;
        repeat (3) tick();
        src_valid = 1; src_rs = 5'd8; src_rt = 5'd1; #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL sb_rs_hazard: got %b want 1", stall); else n_pass++;
        tick();
        src_rs = 5'd9; src_rt = 5'd9; #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL sb_independent: got %b want 0", stall); else n_pass++;
        tick();
        src_rs = 5'd1; src_rt = 5'd8; #1;
        n_checks++; if (stall !== 1'b1) $display("FAIL sb_rt_hazard: got %b want 1", stall); else n_pass++;
        tick();
        src_valid = 0; issue_valid = 1; #1;
        n_checks++; if (stall !== 1'b1 || issue_ready !== 1'b0)
            $display("FAIL sb_issue_busy: got stall=%b ready=%b want 1 0", stall, issue_ready); else n_pass++;
        issue_valid = 0;
        reset = 0; #1; reset = 1;
        tick();
        issue_valid = 1; issue_op = 1'b0; issue_rd = 5'd0;
        tick();
        issue_valid = 0;
        tick();
        src_valid = 1; src_rs = 5'd0; src_rt = 5'd0; #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL sb_rd0: got %b want 0", stall); else n_pass++;
        md_result_rdy = 1; md_result = 32'd77; md_exception = 0;
        tick();
        md_result_rdy = 0; src_valid = 0;
        n_checks++; if (wb_req !== 1'b1 || wb_reg !== 5'd0 || wb_data !== 32'd77)
            $display("FAIL sb_wb_r0: got req=%b reg=%0d data=%0d want 1 0 77", wb_req, wb_reg, wb_data); else n_pass++;
        wb_ack = 1;
        tick();
        wb_ack = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_exceptions();
        test_timeout();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
`ifdef MULTDIV_SCOREBOARD_EN
        test_scoreboard();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
